// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32I core: sequences fetch, decode, execute,
// memory and write-back, trapping on illegal instructions or memory-ack timeout.
module multicycle_control #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned EN_BH   = 1,
    parameter int unsigned EN_SLT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        imem_ack,
    input  logic        dram_ack,
    input  logic        breq,
    input  logic        brlt,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        npc_op,
    output logic        rf_we,
    output logic        brun,
    output logic        asel,
    output logic        bsel,
    output logic        dram_req,
    output logic        dram_we,
    output logic        mem_unsigned,
    output logic        illegal,
    output logic        bus_err,
    output logic [1:0]  wbsel,
    output logic [3:0]  alu_op,
    output logic [2:0]  sext_op,
    output logic [1:0]  mem_size,
    output logic [2:0]  state
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit BH_ON  = (EN_BH != 0);
    localparam bit SLT_ON = (EN_SLT != 0);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_PASSB = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;

    localparam logic [2:0] SEXT_I = 3'd0;
    localparam logic [2:0] SEXT_S = 3'd1;
    localparam logic [2:0] SEXT_U = 3'd2;
    localparam logic [2:0] SEXT_J = 3'd3;
    localparam logic [2:0] SEXT_B = 3'd4;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;
    logic             berr_q, berr_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic       is_load, is_store, is_opimm, is_op;
    logic       dec_legal;
    logic [3:0] dec_alu;
    logic [2:0] dec_sext;
    logic [3:0] alu_f3;
    logic       br_taken;
    logic       timeout;
    logic       unused_inst;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign funct7      = inst[31:25];
    assign timeout     = (cnt_q == CNT_LAST);
    assign state       = state_q;
    assign unused_inst = ^{inst[24:15], inst[11:7]};

    // Instruction class, legality and the ALU/immediate codes held from ID on.
    always_comb begin
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_br     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_opimm  = 1'b0;
        is_op     = 1'b0;
        dec_legal = 1'b0;
        dec_alu   = ALU_ADD;
        dec_sext  = SEXT_I;
        alu_f3    = ALU_ADD;
        case (funct3)
            3'b001:  alu_f3 = ALU_SLL;
            3'b010:  alu_f3 = ALU_SLT;
            3'b011:  alu_f3 = ALU_SLTU;
            3'b100:  alu_f3 = ALU_XOR;
            3'b101:  alu_f3 = inst[30] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_f3 = ALU_OR;
            3'b111:  alu_f3 = ALU_AND;
            default: alu_f3 = ALU_ADD;
        endcase
        case (opcode)
            OPC_LUI: begin
                is_lui    = 1'b1;
                dec_legal = 1'b1;
                dec_alu   = ALU_PASSB;
                dec_sext  = SEXT_U;
            end
            OPC_AUIPC: begin
                is_auipc  = 1'b1;
                dec_legal = 1'b1;
                dec_sext  = SEXT_U;
            end
            OPC_JAL: begin
                is_jal    = 1'b1;
                dec_legal = 1'b1;
                dec_sext  = SEXT_J;
            end
            OPC_JALR: begin
                is_jalr   = 1'b1;
                dec_legal = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                is_br     = 1'b1;
                dec_sext  = SEXT_B;
                dec_legal = funct3[2] ? (!funct3[1] || SLT_ON) : !funct3[1];
            end
            OPC_LOAD: begin
                is_load   = 1'b1;
                dec_legal = (funct3 == 3'b010) || (BH_ON && !funct3[1]);
            end
            OPC_STORE: begin
                is_store  = 1'b1;
                dec_sext  = SEXT_S;
                dec_legal = (funct3 == 3'b010) || (BH_ON && funct3[2:1] == 2'b00);
            end
            OPC_OPIMM: begin
                is_opimm = 1'b1;
                dec_alu  = alu_f3;
                case (funct3)
                    3'b001:         dec_legal = (funct7 == 7'b0000000);
                    3'b101:         dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    3'b010, 3'b011: dec_legal = SLT_ON;
                    default:        dec_legal = 1'b1;
                endcase
            end
            OPC_OP: begin
                is_op   = 1'b1;
                dec_alu = (funct3 == 3'b000 && inst[30]) ? ALU_SUB : alu_f3;
                if (funct7 == 7'b0000000) begin
                    dec_legal = (funct3[2:1] != 2'b01) || SLT_ON;
                end else if (funct7 == 7'b0100000) begin
                    dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:         br_taken = breq;
            3'b001:         br_taken = !breq;
            3'b100, 3'b110: br_taken = brlt;
            default:        br_taken = !brlt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            berr_q  <= berr_d;
        end
    end

    // Next state and per-state controls; the wait counter restarts on any state entry.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        ill_d        = ill_q;
        berr_d       = berr_q;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        npc_op       = 1'b0;
        rf_we        = 1'b0;
        brun         = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        dram_req     = 1'b0;
        dram_we      = 1'b0;
        mem_unsigned = 1'b0;
        illegal      = 1'b0;
        bus_err      = 1'b0;
        wbsel        = 2'd0;
        alu_op       = 4'd0;
        sext_op      = 3'd0;
        mem_size     = 2'd0;
        case (state_q)
            S_IF: begin
                imem_req = rst_n;
                if (imem_ack) begin
                    ir_we   = rst_n;
                    state_d = S_ID;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ID: begin
                alu_op  = dec_alu;
                sext_op = dec_sext;
                if (dec_legal) begin
                    state_d = S_EX;
                end else begin
                    state_d = S_TRAP;
                    ill_d   = 1'b1;
                end
            end
            S_EX: begin
                alu_op  = dec_alu;
                sext_op = dec_sext;
                if (is_br) begin
                    pc_we   = 1'b1;
                    bsel    = 1'b1;
                    npc_op  = br_taken;
                    brun    = funct3[1];
                    state_d = S_IF;
                end else if (is_jal || is_jalr) begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    npc_op  = 1'b1;
                    asel    = is_jalr;
                    bsel    = 1'b1;
                    state_d = S_IF;
                end else if (is_load || is_store) begin
                    asel    = 1'b1;
                    bsel    = 1'b1;
                    state_d = S_MEM;
                end else begin
                    asel    = is_op || is_opimm;
                    bsel    = is_opimm || is_lui || is_auipc;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_op       = dec_alu;
                sext_op      = dec_sext;
                dram_req     = 1'b1;
                dram_we      = is_store;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
                if (dram_ack) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                alu_op  = dec_alu;
                sext_op = dec_sext;
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                wbsel   = is_load ? 2'd2 : 2'd1;
                state_d = S_IF;
            end
            S_TRAP: begin
                illegal = ill_q;
                bus_err = berr_q;
            end
            default: state_d = S_IF;
        endcase
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: number of cycles to wait for a memory ack before trapping; legal range 2..255.
REQ-002 SHALL have parameter EN_BH, default 1: when 1, byte/half loads and stores (lb/lh/lbu/lhu/sb/sh) are legal; when 0 they are illegal.
REQ-003 SHALL have parameter EN_SLT, default 1: when 1, slt/sltu/slti/sltiu and bltu/bgeu are legal; when 0 they are illegal.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port inst, input, 32 bits: instruction register contents, held stable from ID to retire.
REQ-007 SHALL have port imem_ack, input, 1 bit: instruction fetch complete.
REQ-008 SHALL have port dram_ack, input, 1 bit: data access complete.
REQ-009 SHALL have ports breq and brlt, inputs, 1 bit each: branch comparator results.
REQ-010 SHALL have the following outputs, 1 bit each:
- imem_req, ir_we, pc_we
- npc_op: 1 = target, 0 = pc+4
- rf_we
- brun: 1 = unsigned compare
- asel: 1 = rs1, 0 = pc
- bsel: 1 = imm, 0 = rs2
- dram_req, dram_we, mem_unsigned
- illegal, bus_err
REQ-011 SHALL have multi-bit outputs:
- wbsel[1:0]: 0 = pc+4, 1 = alu, 2 = dram
- alu_op[3:0]
- sext_op[2:0]
- mem_size[1:0]: 0 = byte, 1 = half, 2 = word
- state[2:0]

Function
REQ-012 SHALL encode state as IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5.
REQ-013 SHALL use alu_op codes: add 0, sub 1, and 2, or 3, xor 4, sll 5, srl 6, sra 7, passB 8, slt 9, sltu 10.
REQ-014 SHALL use sext_op codes: I 0, S 1, U 2, J 3, B 4.
REQ-015 SHALL drive every output not named for the current state to 0, except sext_op and alu_op, which hold their decoded values in ID, EX, MEM and WB.
REQ-016 IF: SHALL assert imem_req. On imem_ack it SHALL pulse ir_we for one cycle and go to ID.
REQ-017 ID: SHALL decode inst in one cycle. If inst is illegal it SHALL go to TRAP; otherwise it SHALL go to EX.
REQ-018 An instruction SHALL be illegal when:
- its opcode is outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}; or
- funct3/funct7 is unsupported; or
- it is disabled by EN_BH or EN_SLT.
REQ-019 EX, OP/OP-IMM/LUI/AUIPC: SHALL drive ALU controls only and go to WB.
- AUIPC: asel=0, bsel=1, alu_op=add, sext_op=U.
- LUI: alu_op=passB.
REQ-020 EX, branch: SHALL assert pc_we with asel=0, bsel=1, alu_op=add, sext_op=B.
- npc_op = breq for beq, !breq for bne, brlt for blt/bltu, !brlt for bge/bgeu.
- brun = 1 for bltu/bgeu.
- Next state IF.
REQ-021 EX, jal/jalr: SHALL assert rf_we, pc_we, npc_op=1 and wbsel=0, then go to IF.
- jal: asel=0, sext_op=J.
- jalr: asel=1, sext_op=I.
REQ-022 EX, load/store: SHALL compute the address (asel=1, bsel=1, alu_op=add, sext_op I or S) and go to MEM.
REQ-023 MEM: SHALL hold dram_req=1 with mem_size=funct3[1:0] and mem_unsigned=funct3[2]; dram_we=1 for stores only.
- Store + dram_ack: pc_we=1, npc_op=0, next state IF.
- Load + dram_ack: next state WB.
REQ-024 WB: SHALL assert rf_we and pc_we with npc_op=0; wbsel=2 for loads, 1 otherwise; next state IF.
REQ-025 SHALL run a wait counter in IF and MEM, cleared on every state entry and incremented each cycle without ack. When it reaches TIMEOUT-1 with no ack, the FSM SHALL go to TRAP with bus_err=1.
REQ-026 An ack arriving in the same cycle the counter reaches TIMEOUT-1 SHALL take priority; no trap.
REQ-027 TRAP: SHALL hold illegal or bus_err (whichever caused entry) at 1 and all other outputs at 0 until reset; the FSM never leaves TRAP otherwise.
REQ-028 SHALL ignore imem_ack outside IF and dram_ack outside MEM.
REQ-029 Cycles per instruction with zero-wait acks SHALL be:
- branch/jump: 3
- ALU op: 4
- store: 4
- load: 5

Reset
REQ-030 While rst_n=0, the FSM SHALL force state IF, clear the wait counter and the trap flags, and hold all outputs at 0 (imem_req masked).
REQ-031 An assertion of rst_n mid-access SHALL abandon the access immediately.
REQ-032 The first imem_req SHALL appear in the first cycle after rst_n rises.

Verification
REQ-033 add x1,x2,x3 (0x003100B3), acks immediate -> IF,ID,EX,WB; in WB: rf_we=1, wbsel=1, alu_op=0, pc_we=1.
REQ-034 bne with breq=0 -> in EX: pc_we=1, npc_op=1, sext_op=4, asel=0; with breq=1 -> npc_op=0.
REQ-035 lhu with dram_ack delayed 3 cycles -> MEM lasts 4 cycles with mem_size=1, mem_unsigned=1; then WB with wbsel=2.
REQ-036 TIMEOUT=4, imem_ack never asserted -> TRAP entered on the 4th IF cycle; bus_err=1 held; rst_n pulse -> state=IF, bus_err=0.
REQ-037 EN_BH=0 with sb, and inst=0xFFFFFFFF -> ID then TRAP, illegal=1, no dram_req ever asserted.
REQ-038 rst_n driven low during MEM of sw -> dram_req and dram_we drop immediately; no pc_we.
